// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the execute stage: ALU control codes, R-type funct
// values and the main-decoder ALU-op classes.
package alu_exec_unit_pkg;

   typedef enum logic [2:0] {
      CTL_AND  = 3'b000,
      CTL_OR   = 3'b001,
      CTL_ADD  = 3'b010,
      CTL_XOR  = 3'b011,
      CTL_NOR  = 3'b100,
      CTL_RSVD = 3'b101,
      CTL_SUB  = 3'b110,
      CTL_SLT  = 3'b111
   } alu_ctl_e;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_XOR = 6'b100110;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // Upper bit set means "R-type, look at funct"; the low bit is then ignored.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/alu_exec_unit_decoder.sv
// Combinational ALU control decoder: maps the main-decoder ALU-op class and
// the R-type funct field onto a 3-bit ALU control code.
module alu_ctl_decoder
   import alu_exec_unit_pkg::*;
(
   input  logic       alu_op1_i,
   input  logic       alu_op0_i,
   input  logic [5:0] funct_i,
   output alu_ctl_e   alu_ctl_o
);

   // Unknown funct values fall back to ADD rather than the reserved code.
   always_comb begin
      alu_ctl_o = CTL_ADD;
      if (alu_op1_i) begin
         case (funct_i)
            FUNCT_ADD: alu_ctl_o = CTL_ADD;
            FUNCT_SUB: alu_ctl_o = CTL_SUB;
            FUNCT_AND: alu_ctl_o = CTL_AND;
            FUNCT_OR:  alu_ctl_o = CTL_OR;
            FUNCT_XOR: alu_ctl_o = CTL_XOR;
            FUNCT_NOR: alu_ctl_o = CTL_NOR;
            FUNCT_SLT: alu_ctl_o = CTL_SLT;
            default:   alu_ctl_o = CTL_ADD;
         endcase
      end else if (alu_op0_i) begin
         alu_ctl_o = CTL_SUB;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU, sequential-PC and branch-target adders, all registered
// with a single cycle of latency; outputs hold while no new input is valid.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int PC_INC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             alu_op1,
   input  logic             alu_op0,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] br_offset,
   output logic             out_valid,
   output logic [2:0]       alu_ctl,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] pc_plus_inc,
   output logic [WIDTH-1:0] br_target
);

   alu_ctl_e         aluCtl_d;
   logic [WIDTH-1:0] aluResult_d;
   logic             zero_d;
   logic [WIDTH-1:0] pcPlusInc_d;
   logic [WIDTH-1:0] brTarget_d;

   logic             outValid_q;
   alu_ctl_e         aluCtl_q;
   logic [WIDTH-1:0] aluResult_q;
   logic             zero_q;
   logic [WIDTH-1:0] pcPlusInc_q;
   logic [WIDTH-1:0] brTarget_q;

   alu_ctl_decoder u_decoder (
      .alu_op1_i (alu_op1),
      .alu_op0_i (alu_op0),
      .funct_i   (funct),
      .alu_ctl_o (aluCtl_d)
   );

   // Plain modulo-2^WIDTH arithmetic; SLT compares as two's complement.
   always_comb begin
      aluResult_d = '0;
      case (aluCtl_d)
         CTL_AND:  aluResult_d = op_a & op_b;
         CTL_OR:   aluResult_d = op_a | op_b;
         CTL_XOR:  aluResult_d = op_a ^ op_b;
         CTL_NOR:  aluResult_d = ~(op_a | op_b);
         CTL_ADD:  aluResult_d = op_a + op_b;
         CTL_SUB:  aluResult_d = op_a - op_b;
         CTL_SLT:  aluResult_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default:  aluResult_d = '0;
      endcase
   end

   always_comb begin
      zero_d      = (aluResult_d == '0);
      pcPlusInc_d = pc + WIDTH'(PC_INC);
      brTarget_d  = pcPlusInc_d + br_offset;
   end

   // Payload registers only load on a valid input so idle cycles keep the last result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q  <= 1'b0;
         aluCtl_q    <= CTL_AND;
         aluResult_q <= '0;
         zero_q      <= 1'b0;
         pcPlusInc_q <= '0;
         brTarget_q  <= '0;
      end else begin
         outValid_q <= in_valid;
         if (in_valid) begin
            aluCtl_q    <= aluCtl_d;
            aluResult_q <= aluResult_d;
            zero_q      <= zero_d;
            pcPlusInc_q <= pcPlusInc_d;
            brTarget_q  <= brTarget_d;
         end
      end
   end

   assign out_valid   = outValid_q;
   assign alu_ctl     = aluCtl_q;
   assign result      = aluResult_q;
   assign zero        = zero_q;
   assign pc_plus_inc = pcPlusInc_q;
   assign br_target   = brTarget_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares one cycle later.
module tb_alu_exec_unit;

   localparam int W = 32;

   typedef struct {
      logic         valid;
      logic [2:0]   ctl;
      logic [W-1:0] res;
      logic         zf;
      logic [W-1:0] pcInc;
      logic [W-1:0] brT;
   } expect_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         alu_op1;
   logic         alu_op0;
   logic [5:0]   funct;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] pc;
   logic [W-1:0] br_offset;
   logic         out_valid;
   logic [2:0]   alu_ctl;
   logic [W-1:0] result;
   logic         zero;
   logic [W-1:0] pc_plus_inc;
   logic [W-1:0] br_target;

   expect_t scoreQ[$];
   expect_t held;
   int vectors    = 0;
   int miscompares = 0;

   alu_exec_unit #(.WIDTH(W), .PC_INC(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .alu_op1     (alu_op1),
      .alu_op0     (alu_op0),
      .funct       (funct),
      .op_a        (op_a),
      .op_b        (op_b),
      .pc          (pc),
      .br_offset   (br_offset),
      .out_valid   (out_valid),
      .alu_ctl     (alu_ctl),
      .result      (result),
      .zero        (zero),
      .pc_plus_inc (pc_plus_inc),
      .br_target   (br_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: pick the operation by name, then do the arithmetic directly.
   function automatic string opName(input logic o1, input logic o0, input logic [5:0] f);
      if (!o1) return o0 ? "SUB" : "ADD";
      case (f)
         6'b100000: return "ADD";
         6'b100010: return "SUB";
         6'b100100: return "AND";
         6'b100101: return "OR";
         6'b100110: return "XOR";
         6'b100111: return "NOR";
         6'b101010: return "SLT";
         default:   return "ADD";
      endcase
   endfunction

   function automatic expect_t model(input logic o1, input logic o0, input logic [5:0] f,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] p, input logic [W-1:0] off);
      expect_t e;
      string nm;
      nm = opName(o1, o0, f);
      e.valid = 1'b1;
      case (nm)
         "AND":   begin e.ctl = 3'b000; e.res = a & b; end
         "OR":    begin e.ctl = 3'b001; e.res = a | b; end
         "XOR":   begin e.ctl = 3'b011; e.res = a ^ b; end
         "NOR":   begin e.ctl = 3'b100; e.res = ~(a | b); end
         "SUB":   begin e.ctl = 3'b110; e.res = a - b; end
         "SLT":   begin e.ctl = 3'b111; e.res = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0; end
         default: begin e.ctl = 3'b010; e.res = a + b; end
      endcase
      e.zf    = (e.res == 0);
      e.pcInc = p + 32'd4;
      e.brT   = p + 32'd4 + off;
      return e;
   endfunction

   task automatic applyStimulus(input logic v, input logic o1, input logic o0, input logic [5:0] f,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] p, input logic [W-1:0] off);
      expect_t e;
      @(negedge clk);
      in_valid = v; alu_op1 = o1; alu_op0 = o0; funct = f;
      op_a = a; op_b = b; pc = p; br_offset = off;
      if (v) begin
         held = model(o1, o0, f, a, b, p, off);
         e = held;
      end else begin
         e = held;
         e.valid = 1'b0;
      end
      scoreQ.push_back(e);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " out_valid"}, W'(out_valid), '0);
      checkOutput({tag, " alu_ctl"}, W'(alu_ctl), '0);
      checkOutput({tag, " result"}, result, '0);
      checkOutput({tag, " zero"}, W'(zero), '0);
      checkOutput({tag, " pc_plus_inc"}, pc_plus_inc, '0);
      checkOutput({tag, " br_target"}, br_target, '0);
   endtask

   // Monitor: every entry pushed before an edge describes the state after it.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #2;
         if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput("out_valid", W'(out_valid), W'(e.valid));
            checkOutput("alu_ctl", W'(alu_ctl), W'(e.ctl));
            checkOutput("result", result, e.res);
            checkOutput("zero", W'(zero), W'(e.zf));
            checkOutput("pc_plus_inc", pc_plus_inc, e.pcInc);
            checkOutput("br_target", br_target, e.brT);
         end
      end
   end

   initial begin
      logic [5:0] functTbl [8];
      functTbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                   6'b100110, 6'b100111, 6'b101010, 6'b111111};
      held = '{valid: 1'b0, ctl: 3'b000, res: '0, zf: 1'b0, pcInc: '0, brT: '0};
      rst_n = 1'b0; in_valid = 1'b0; alu_op1 = 1'b0; alu_op0 = 1'b0; funct = '0;
      op_a = '0; op_b = '0; pc = '0; br_offset = '0;
      #3;
      checkAllZero("reset");
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Directed vectors from the known-answer list.
      applyStimulus(1, 0, 0, 6'h00, 32'd5, 32'd3, 32'h100, 32'd8);
      applyStimulus(1, 0, 1, 6'h00, 32'd7, 32'd7, 32'h104, 32'd0);
      applyStimulus(1, 1, 0, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'h108, 32'd0);
      applyStimulus(1, 1, 0, 6'b100111, 32'd0, 32'd0, 32'h10C, 32'd0);
      applyStimulus(1, 1, 0, 6'b111111, 32'd9, 32'd6, 32'h110, 32'd0);
      applyStimulus(1, 0, 0, 6'h00, 32'hFFFFFFFF, 32'd1, 32'h10, 32'hFFFFFFF8);
      applyStimulus(1, 1, 1, 6'b100010, 32'h80000000, 32'd1, 32'hFFFFFFFC, 32'd4);
      applyStimulus(1, 1, 0, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'h20, 32'd0);

      // Three back-to-back results, then idle cycles that must hold them.
      applyStimulus(1, 1, 0, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h200, 32'h40);
      applyStimulus(1, 1, 0, 6'b100101, 32'h0F0F0000, 32'h000000F0, 32'h204, 32'h40);
      applyStimulus(1, 1, 0, 6'b100110, 32'hAAAA5555, 32'hFFFF0000, 32'h208, 32'h40);
      applyStimulus(0, 0, 0, 6'h00, 32'd1, 32'd2, 32'h300, 32'd0);
      applyStimulus(0, 1, 1, 6'h2A, 32'd3, 32'd4, 32'h304, 32'd0);

      for (int i = 0; i < 200; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? 6'($urandom) : functTbl[$urandom_range(0, 7)],
                       ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                       ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom,
                       $urandom, $urandom);
      end

      // Mid-stream asynchronous reset between edges, with a valid input waiting.
      applyStimulus(1, 0, 0, 6'h00, 32'd11, 32'd22, 32'h400, 32'd16);
      @(negedge clk);
      in_valid = 1'b1; alu_op1 = 1'b0; alu_op0 = 1'b1; funct = '0;
      op_a = 32'd50; op_b = 32'd8; pc = 32'h500; br_offset = 32'hFFFFFFF0;
      #1 rst_n = 1'b0;
      #1 checkAllZero("async reset");
      #1 rst_n = 1'b1;
      held = model(1'b0, 1'b1, 6'h00, 32'd50, 32'd8, 32'h500, 32'hFFFFFFF0);
      scoreQ.push_back(held);
      applyStimulus(1, 1, 0, 6'b100000, 32'd100, 32'd23, 32'h504, 32'd0);
      applyStimulus(0, 0, 0, 6'h00, 32'd0, 32'd0, 32'h0, 32'd0);

      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("scoreboard drained", W'(scoreQ.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
